seq_addsub_unit: RTL and testbench
==================================

// Module: seq_addsub_unit
// PURPOSE
//  Parametrised digit-serial add/subtract unit; successor to the fixed 8-bit combinational ripple adder.
//  Processes DIGIT bits per clock over WIDTH/DIGIT cycles, trading latency for area.
//  Adds subtract mode, carry/borrow-in, signed overflow and a valid/ready handshake on both sides.
//  Sits between the pin-level wrapper and any operand source or sink that can stall.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; WIDTH % DIGIT == 0 required, elaboration error otherwise.
//  DIGIT  2  bits processed per cycle, 1..WIDTH; NDIG = WIDTH/DIGIT.
// PORTS
//  clk        in   1      sole clock; all state updates on the rising edge.
//  rst        in   1      synchronous, active-high reset.
//  in_valid   in   1      operand request valid.
//  in_ready   out  1      unit can accept operands.
//  in_a       in   WIDTH  operand A.
//  in_b       in   WIDTH  operand B.
//  in_cin     in   1      carry-in (ADD) or borrow-in (SUB).
//  in_op      in   1      0 = ADD (A+B+cin); 1 = SUB (A-B-cin).
//  out_valid  out  1      result valid.
//  out_ready  in   1      sink accepts the result.
//  out_sum    out  WIDTH  result.
//  out_cout   out  1      raw MSB carry-out (SUB: 1 = no borrow).
//  out_ovf    out  1      signed overflow: carry into MSB XOR carry out of MSB.
// BEHAVIOUR
//  Reset values: in_ready=1; out_valid=0; out_sum=0; out_cout=0; out_ovf=0; state=IDLE.
//  FSM states:
//   IDLE: in_ready=1. On in_valid: capture A; capture B or ~B; capture carry = cin (ADD) or ~cin (SUB); digit index = 0; go to RUN.
//   RUN: in_ready=0. Each cycle adds digit i via the slice, writes sum digit i and the carry register.
//     On i == NDIG-1: latch cout and ovf, raise out_valid, go to DONE.
//   DONE: out_valid=1. out_sum, out_cout and out_ovf are held stable until out_valid && out_ready; then return to IDLE.
//     in_ready stays 0 in DONE; there is no accept on the same edge as the drain.
//  Latency: result visible after NDIG rising edges following the accepting edge. Throughput: one op per NDIG+2 cycles at best.
//  Inputs are sampled only on the accepting edge. Later changes to in_* have no effect.
//  Sum wraps modulo 2^WIDTH.
//  ovf is computed in the final digit from the slice's carry into the MSB.
//  rst asserted in any state: next state IDLE, in-flight operation discarded, all outputs take their reset values.
//  DIGIT == WIDTH is legal: RUN lasts exactly one cycle.
// CONFIGURATION
//  Macro ADDSUB_SAT_EN:
//   Defined: when ovf=1, out_sum saturates to signed max 0111..1 (positive overflow) or min 1000..0 (negative overflow).
//     out_ovf and out_cout still report the raw result.
//   Undefined: out_sum is always the wrapped two's-complement result. The saturation logic is not present.
// STRUCTURE
//  Package addsub_pkg:
//   - op_e enum {OP_ADD, OP_SUB}.
//   - state_e enum {S_IDLE, S_RUN, S_DONE}.
//   - function for the digit-index counter width, $clog2(NDIG) with a minimum of 1.
//  Sub-module addsub_digit (combinational DIGIT-bit ripple slice):
//   - inputs: a, b, cin.
//   - outputs: s, cout, c_msb (carry into the slice's top bit).
//  Operands are held in shift registers that shift right by DIGIT per RUN cycle. The sum fills in from the top.
// TESTING (WIDTH=8, DIGIT=2 unless stated)
//  1. ADD 0x7F+0x01, cin=0 -> sum 0x80, cout 0, ovf 1, after 4 cycles.
//     With ADDSUB_SAT_EN defined: sum 0x7F.
//  2. ADD 0xFF+0x01, cin=0 -> sum 0x00, cout 1, ovf 0.
//     Also ADD 0x12+0x34, cin=1 -> sum 0x47.
//  3. SUB 0x05-0x07, cin=0 -> 0xFE, cout 0, ovf 0.
//     SUB 0x80-0x01 -> 0x7F, ovf 1 (SAT build: 0x80).
//  4. Backpressure: hold out_ready=0 for 10 cycles -> out_* stable, in_ready=0 throughout.
//     Release -> IDLE next cycle.
//  5. Assert rst on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0.
//     Then ADD 0x12+0x34 -> sum 0x46 with 4-cycle latency.
//  6. Rebuild with DIGIT=8 and DIGIT=1 -> latency 1 and 8 respectively.
//     Random A/B/op/cin checked against a reference model, 1000 ops each.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Digit-index counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its top bit.
module addsub_digit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        c[0] = cin;
        s    = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[DIGIT];
        c_msb = c[DIGIT-1];
    end

endmodule

// File: rtl/seq_addsub_unit.sv
// Digit-serial add/subtract unit with valid/ready on both sides.
// Optional saturation of out_sum on signed overflow: define ADDSUB_SAT_EN.
module seq_addsub_unit
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = cnt_width(NDIG);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("seq_addsub_unit: WIDTH must be a multiple of DIGIT");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d, sum_next;
    logic [CW-1:0]     idx_q, idx_d;
    logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [DIGIT-1:0]  dig_s;
    logic              dig_cout, dig_cmsb, last_dig, is_sub;

    assign is_sub   = (op_e'(in_op) == OP_SUB);
    assign last_dig = (idx_q == CW'(NDIG - 1));

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .s     (dig_s),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    // Sum digits enter at the top so the LSB digit lands at bit 0 after NDIG shifts.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign sum_next = dig_s;
    end else begin : g_multi_digit
        assign sum_next = {dig_s, sum_q[WIDTH-1:DIGIT]};
    end

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SMAX = ~SMIN;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_RUN;
            S_RUN:   if (last_dig)  state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // SUB is A + ~B + ~bin.
                    a_d     = in_a;
                    b_d     = is_sub ? ~in_b : in_b;
                    carry_d = is_sub ? ~in_cin : in_cin;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                sum_d   = sum_next;
                idx_d   = idx_q + CW'(1);
                if (last_dig) begin
                    cout_d = dig_cout;
                    ovf_d  = dig_cout ^ dig_cmsb;
`ifdef ADDSUB_SAT_EN
                    // Wrapped MSB set means the true result overflowed positive.
                    if (dig_cout ^ dig_cmsb) sum_d = dig_s[DIGIT-1] ? SMAX : SMIN;
`endif
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Self-checking bench for seq_addsub_unit: directed literal cases plus randomized ops vs a model.
module tb_seq_addsub_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
);

    localparam int unsigned W    = WIDTH;
    localparam int unsigned NDIG = WIDTH / DIGIT;

    logic         clk, rst;
    logic         in_valid, in_ready, in_cin, in_op;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_cout, out_ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    int   acc_cyc;
    bit   prev_valid;

    seq_addsub_unit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer arithmetic, then wrap / range-check.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic op);
        exp_t   e;
        longint ua, ub, sa, sb, ur, sr, smax, smin;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        if (op == 1'b0) begin
            ur  = ua + ub + longint'(cin);
            sr  = sa + sb + longint'(cin);
            e.c = (ur >= (longint'(1) << W));
        end else begin
            ur  = ua - ub - longint'(cin);
            sr  = sa - sb - longint'(cin);
            e.c = (ur >= 0);
        end
        e.s = ur[W-1:0];
        e.o = (sr > smax) || (sr < smin);
`ifdef ADDSUB_SAT_EN
        if (e.o) begin
            ur  = (sr > 0) ? smax : smin;
            e.s = ur[W-1:0];
        end
`endif
        return e;
    endfunction

    // Compare process: every cycle, outputs must match the model's view of the pipeline.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() == 0) begin
                check("idle_in_ready", in_ready, 1);
                check("idle_out_valid", out_valid, 0);
            end else if (!out_valid) begin
                check("busy_in_ready", in_ready, 0);
            end else begin
                check("out_sum", out_sum, exp_q[0].s);
                check("out_cout", out_cout, exp_q[0].c);
                check("out_ovf", out_ovf, exp_q[0].o);
                check("done_in_ready", in_ready, 0);
                if (!prev_valid) check("latency", cyc - acc_cyc, NDIG);
            end
            prev_valid = out_valid;
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_cin, in_op));
                acc_cyc = cyc + 1;
            end
        end else begin
            exp_q.delete();
            prev_valid = 1'b0;
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic op, input int hold, input bit lit,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        // Scramble inputs after the accepting edge; they must have no effect.
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom);
        in_cin = 1'($urandom); in_op = 1'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("result_timeout", out_valid, 1);
        if (lit) begin
            check("lit_latency", n, NDIG);
            check("lit_sum", out_sum, es);
            check("lit_cout", out_cout, ec);
            check("lit_ovf", out_ovf, eo);
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_in_ready", in_ready, 1);
        check("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;

        if (W == 8) begin
`ifdef ADDSUB_SAT_EN
            run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1, 8'h7F, 1'b0, 1'b1);
            run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 1, 8'h80, 1'b1, 1'b1);
`else
            run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1, 8'h80, 1'b0, 1'b1);
            run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 1, 8'h7F, 1'b1, 1'b1);
`endif
            run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1, 8'h00, 1'b1, 1'b0);
            run_op(8'h12, 8'h34, 1'b1, 1'b0, 0, 1, 8'h47, 1'b0, 1'b0);
            run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 1, 8'hFE, 1'b0, 1'b0);
            // Backpressure: result held for 10 cycles.
            run_op(8'h21, 8'h43, 1'b0, 1'b0, 10, 1, 8'h64, 1'b0, 1'b0);

            // Reset during the second RUN cycle discards the operation.
            in_a = 8'hAA; in_b = 8'h11; in_cin = 1'b0; in_op = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("midrst_in_ready", in_ready, 1);
            check("midrst_out_valid", out_valid, 0);
            check("midrst_out_sum", out_sum, 0);
            run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1, 8'h46, 1'b0, 1'b0);
        end

        for (int k = 0; k < 1000; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), 0, '0, 1'b0, 1'b0);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
